led_frame_packer: RTL and testbench

//  Upstream stage of the LED serial transmitter. Collects per-pixel colour/brightness

---
 rtl/led_frame_packer_if.sv | 35 +++
 rtl/led_frame_packer.sv | 164 ++++++++++++++++
 tb/tb_led_frame_packer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_packer_if.sv
// Pixel write bus for led_frame_packer.
// master: pix_valid/idx/bright/r/g/b out, pix_ready in; slave mirrors.
interface led_frame_packer_if #(
  parameter int LED_NUM = 4
);
  localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

  logic             pix_valid;
  logic             pix_ready;
  logic [IDX_W-1:0] pix_idx;
  logic [4:0]       pix_bright;
  logic [7:0]       pix_r;
  logic [7:0]       pix_g;
  logic [7:0]       pix_b;

  modport master (
    output pix_valid,
    output pix_idx,
    output pix_bright,
    output pix_r,
    output pix_g,
    output pix_b,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_idx,
    input  pix_bright,
    input  pix_r,
    input  pix_g,
    input  pix_b,
    output pix_ready
  );
endinterface

// File: rtl/led_frame_packer.sv
// LED frame packer: collects pixel writes into a bank, snapshots it
// on commit/refresh, strobes frame_en, then waits out a holdoff.
// Ports: clk, rstn (sync, active low), pix (pixel bus slave),
//   commit, frame_en, frame_data[LED_NUM*32], busy.
// Option: LED_PACK_GLOBAL_BRIGHT_EN adds global_bright[4:0], which
//   replaces every stored brightness when the frame is packed.
module led_frame_packer #(
  parameter int LED_NUM        = 4,
  parameter int HOLDOFF_CYCLES = 2200,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  led_frame_packer_if.slave      pix,
  input  logic                   commit,
`ifdef LED_PACK_GLOBAL_BRIGHT_EN
  input  logic [4:0]             global_bright,
`endif
  output logic                   frame_en,
  output logic [LED_NUM*32-1:0]  frame_data,
  output logic                   busy
);

  localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int HO_M  = (HOLDOFF_CYCLES > 2) ? HOLDOFF_CYCLES : 2;
  localparam int RF_M  = (REFRESH_CYCLES > 2) ? REFRESH_CYCLES : 2;
  localparam int HW    = $clog2(HO_M);
  localparam int RW    = $clog2(RF_M);
  localparam int FW    = LED_NUM * 32;

  localparam logic [HW-1:0] HOLD_LAST =
    HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
  localparam logic [RW-1:0] REF_LAST =
    RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam logic [IDX_W:0] NUM_X = (IDX_W + 1)'(LED_NUM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic            ref_tick;
  logic            pend_q, pend_d;
  logic            ready_q, ready_d;
  logic            fen_q, fen_d;
  logic            busy_q, busy_d;
  logic [FW-1:0]   data_q, data_d;
  logic [FW-1:0]   packed_w;
  logic            idx_ok;
  logic            wr_en;

  // bank entry = {bright[4:0], B, G, R}; the 3'b111 prefix is implicit
  logic [28:0]     bank_q [LED_NUM];
  logic [28:0]     bank_d [LED_NUM];

  assign idx_ok = {1'b0, pix.pix_idx} < NUM_X;
  assign wr_en  = pix.pix_valid & ready_q & idx_ok;

  always_comb begin : bank_c
    for (int i = 0; i < LED_NUM; i++) begin
      bank_d[i] = bank_q[i];
    end
    if (wr_en) begin
      bank_d[pix.pix_idx] = {pix.pix_bright, pix.pix_b,
                             pix.pix_g, pix.pix_r};
    end
  end

  // pixel 0 lands in the most significant word
  always_comb begin : pack_c
    packed_w = '0;
    for (int i = 0; i < LED_NUM; i++) begin
`ifdef LED_PACK_GLOBAL_BRIGHT_EN
      packed_w[(LED_NUM-i)*32-1 -: 32] =
        {3'b111, global_bright, bank_q[i][23:0]};
`else
      packed_w[(LED_NUM-i)*32-1 -: 32] = {3'b111, bank_q[i]};
`endif
    end
  end

  always_comb begin : ref_c
    ref_d    = '0;
    ref_tick = 1'b0;
    if (REFRESH_CYCLES > 0) begin
      ref_tick = (ref_q == REF_LAST);
      ref_d    = ref_tick ? '0 : ref_q + 1'b1;
    end
  end

  always_comb begin : fsm_c
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    pend_d  = pend_q | commit | ref_tick;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q || commit) begin
          // requests seen up to now are folded into this frame
          state_d = S_LOAD;
          pend_d  = 1'b0;
        end
      end
      S_LOAD: begin
        data_d  = packed_w;
        state_d = S_FIRE;
      end
      S_FIRE: begin
        hold_d  = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    fen_d   = (state_d == S_FIRE);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d != S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      ref_q   <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      fen_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < LED_NUM; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ref_q   <= ref_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      fen_q   <= fen_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      for (int i = 0; i < LED_NUM; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign pix.pix_ready = ready_q;
  assign frame_en      = fen_q;
  assign frame_data    = data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_led_frame_packer.sv
// Testbench for led_frame_packer: directed + random pixel writes
// checked against a per-pixel model; second instance covers refresh.
module tb_led_frame_packer;
  localparam int LN = 3;
  localparam int HO = 40;
  localparam int RP = 200;
  localparam int FW = LN * 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rstn_r = 1'b0;
  logic          commit = 1'b0;
  logic          commit_r = 1'b0;
  logic          frame_en, busy;
  logic          frame_en_r, busy_r;
  logic [FW-1:0] frame_data, frame_data_r;
`ifdef LED_PACK_GLOBAL_BRIGHT_EN
  logic [4:0]    gb = 5'h03;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  led_frame_packer_if #(.LED_NUM(LN)) p_if ();
  led_frame_packer_if #(.LED_NUM(LN)) r_if ();

  led_frame_packer #(
    .LED_NUM(LN), .HOLDOFF_CYCLES(HO), .REFRESH_CYCLES(0)
  ) u_dut (
    .clk(clk), .rstn(rstn), .pix(p_if), .commit(commit),
`ifdef LED_PACK_GLOBAL_BRIGHT_EN
    .global_bright(gb),
`endif
    .frame_en(frame_en), .frame_data(frame_data), .busy(busy)
  );

  led_frame_packer #(
    .LED_NUM(LN), .HOLDOFF_CYCLES(HO), .REFRESH_CYCLES(RP)
  ) u_ref (
    .clk(clk), .rstn(rstn_r), .pix(r_if), .commit(commit_r),
`ifdef LED_PACK_GLOBAL_BRIGHT_EN
    .global_bright(gb),
`endif
    .frame_en(frame_en_r), .frame_data(frame_data_r), .busy(busy_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] m_br [LN];
  logic [7:0] m_r [LN];
  logic [7:0] m_g [LN];
  logic [7:0] m_b [LN];

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] exp_frame();
    logic [FW-1:0] f;
    logic [4:0] br;
    f = '0;
    for (int i = 0; i < LN; i++) begin
`ifdef LED_PACK_GLOBAL_BRIGHT_EN
      br = gb;
`else
      br = m_br[i];
`endif
      f[(LN-i)*32-1 -: 32] = {3'b111, br, m_b[i], m_g[i], m_r[i]};
    end
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LN; i++) begin
      m_br[i] = '0; m_r[i] = '0; m_g[i] = '0; m_b[i] = '0;
    end
  endtask

  // frame monitors
  int            fe_cyc[$];
  logic [FW-1:0] fe_dat[$];
  int            rf_cyc[$];
  logic [FW-1:0] rf_dat[$];
  logic          prev_fe = 1'b0;
  logic          prev_rf = 1'b0;

  always @(negedge clk) begin
    if (prev_fe === 1'b1) check("fe_single", frame_en, 1'b0);
    if (prev_rf === 1'b1) check("rf_single", frame_en_r, 1'b0);
    if (frame_en === 1'b1) begin
      fe_cyc.push_back(cyc);
      fe_dat.push_back(frame_data);
    end
    if (frame_en_r === 1'b1) begin
      rf_cyc.push_back(cyc);
      rf_dat.push_back(frame_data_r);
    end
    prev_fe = frame_en;
    prev_rf = frame_en_r;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(input string tag, output int c,
                            output logic [FW-1:0] d);
    int i;
    i = 0;
    while (fe_cyc.size() == 0 && i < 4 * HO) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (fe_cyc.size() == 0) begin
      check({tag, "_timeout"}, fe_cyc.size(), 1);
      c = -1;
      d = '0;
    end else begin
      c = fe_cyc.pop_front();
      d = fe_dat.pop_front();
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < 4 * HO) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic do_commit(output int k);
    commit = 1'b1;
    k = cyc;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [4:0] br,
                    input logic [7:0] r, input logic [7:0] g,
                    input logic [7:0] b);
    int i;
    p_if.pix_valid  = 1'b1;
    p_if.pix_idx    = 2'(idx);
    p_if.pix_bright = br;
    p_if.pix_r      = r;
    p_if.pix_g      = g;
    p_if.pix_b      = b;
    i = 0;
    while (p_if.pix_ready !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("wr_ready", p_if.pix_ready, 1'b1);
    @(negedge clk);
    p_if.pix_valid = 1'b0;
    if (idx < LN) begin
      m_br[idx] = br; m_r[idx] = r; m_g[idx] = g; m_b[idx] = b;
    end
  endtask

  initial begin
    int k, k0, c, c1, c2, n;
    logic [FW-1:0] d, d1, exp_a, exp_r;
    logic [31:0] w;

    p_if.pix_valid = 1'b0;
    p_if.pix_idx = '0;
    p_if.pix_bright = '0;
    p_if.pix_r = '0; p_if.pix_g = '0; p_if.pix_b = '0;
    r_if.pix_valid = 1'b0;
    r_if.pix_idx = '0;
    r_if.pix_bright = '0;
    r_if.pix_r = '0; r_if.pix_g = '0; r_if.pix_b = '0;
    model_reset();

    // reset state
    tick(3);
    check("rst_ready", p_if.pix_ready, 1'b0);
    check("rst_fen", frame_en, 1'b0);
    check("rst_data", frame_data, '0);
    check("rst_busy", busy, 1'b0);
    rstn = 1'b1;
    rstn_r = 1'b1;

    // refresh instance: one pixel written, then left alone
    r_if.pix_valid = 1'b1;
    r_if.pix_idx = 2'd2;
    r_if.pix_bright = 5'h0A;
    r_if.pix_r = 8'hA1; r_if.pix_g = 8'hB2; r_if.pix_b = 8'hC3;
    tick(3);
    r_if.pix_valid = 1'b0;

    // T1: single pixel, commit latency
    wr(0, 5'h1F, 8'h11, 8'h22, 8'h33);
    do_commit(k);
    wait_frame("t1", c, d);
    check("t1_lat", c, k + 2);
    check("t1_data", d, exp_frame());
    w = d[95:64];
`ifdef LED_PACK_GLOBAL_BRIGHT_EN
    check("t1_word0", w, 32'hE333_2211);
`else
    check("t1_word0", w, 32'hFF33_2211);
`endif
    w = d[63:32];
    check("t1_word1", w, 32'hE000_0000);
    check("t1_busy", busy, 1'b1);
    wait_idle("t1");

    // T2: coalesced commits during holdoff
    do_commit(k0);
    wait_frame("t2a", c1, d1);
    check("t2_lat", c1, k0 + 2);
    while (cyc < k0 + 10) @(negedge clk);
    do_commit(k);
    while (cyc < k0 + HO - 5) @(negedge clk);
    do_commit(k);
    wait_frame("t2b", c2, d);
    check("t2_gap", c2 - c1, HO + 3);
    check("t2_data", d, exp_frame());
    tick(3 * HO);
    check("t2_no_third", fe_cyc.size(), 0);
    wait_idle("t2");

    // T3: write held across LOAD lands after the snapshot
    p_if.pix_valid = 1'b1;
    p_if.pix_idx = 2'd1;
    p_if.pix_bright = 5'h05;
    p_if.pix_r = 8'hA0; p_if.pix_g = 8'hA1; p_if.pix_b = 8'hA2;
    commit = 1'b1;
    k = cyc;
    @(negedge clk);
    commit = 1'b0;
    m_br[1] = 5'h05; m_r[1] = 8'hA0; m_g[1] = 8'hA1; m_b[1] = 8'hA2;
    exp_a = exp_frame();
    check("t3_rdy_load", p_if.pix_ready, 1'b0);
    p_if.pix_bright = 5'h1A;
    p_if.pix_r = 8'h5B; p_if.pix_g = 8'h6C; p_if.pix_b = 8'h7D;
    @(negedge clk);
    check("t3_rdy_fire", p_if.pix_ready, 1'b1);
    @(negedge clk);
    p_if.pix_valid = 1'b0;
    check("t3_rdy_hold", p_if.pix_ready, 1'b1);
    m_br[1] = 5'h1A; m_r[1] = 8'h5B; m_g[1] = 8'h6C; m_b[1] = 8'h7D;
    wait_frame("t3a", c, d);
    check("t3_lat", c, k + 2);
    check("t3_snap", d, exp_a);
    tick(5);
    check("t3_hold_data", frame_data, exp_a);
    wait_idle("t3");
    tick(2);
    check("t3_idle_data", frame_data, exp_a);
    check("t3_idle_rdy", p_if.pix_ready, 1'b1);
    do_commit(k);
    wait_frame("t3b", c, d);
    check("t3_next", d, exp_frame());
    wait_idle("t3b");

    // out-of-range index is discarded
    wr(3, 5'h11, 8'hEE, 8'hEE, 8'hEE);
    do_commit(k);
    wait_frame("oor", c, d);
    check("oor_data", d, exp_frame());
    wait_idle("oor");

    // random rounds
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(2, 6);
      for (int j = 0; j < n; j++) begin
        wr($urandom_range(0, 3), 5'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom));
      end
      do_commit(k);
      wait_frame("rnd", c, d);
      check("rnd_lat", c, k + 2);
      check("rnd_data", d, exp_frame());
      wait_idle("rnd");
    end

    // T5: reset during HOLD with a pending commit
    do_commit(k);
    wait_frame("t5", c, d);
    tick(5);
    do_commit(k);
    tick(3);
    rstn = 1'b0;
    @(negedge clk);
    check("t5_rst_fen", frame_en, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_data", frame_data, '0);
    tick(2);
    rstn = 1'b1;
    model_reset();
    tick(3 * HO);
    check("t5_no_frame", fe_cyc.size(), 0);
    check("t5_data", frame_data, '0);
    check("t5_busy", busy, 1'b0);

    // refresh instance: period and content
    while (cyc < 3 * RP + 60) @(negedge clk);
`ifdef LED_PACK_GLOBAL_BRIGHT_EN
    exp_r = {32'hE300_0000, 32'hE300_0000,
             {3'b111, gb, 8'hC3, 8'hB2, 8'hA1}};
`else
    exp_r = {32'hE000_0000, 32'hE000_0000,
             {3'b111, 5'h0A, 8'hC3, 8'hB2, 8'hA1}};
`endif
    check("rf_count", rf_cyc.size() >= 3, 1'b1);
    if (rf_cyc.size() >= 3) begin
      check("rf_gap1", rf_cyc[1] - rf_cyc[0], RP);
      check("rf_gap2", rf_cyc[2] - rf_cyc[1], RP);
      check("rf_data0", rf_dat[0], exp_r);
      check("rf_data2", rf_dat[2], exp_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
